haar_inv_col_merge: RTL and testbench

Downstream stage of the inverse Haar row stage. Each accepted beat carries the intermediate L0/L1/H0/H1 values for three colour channels and is combined into a 2x2 block of reconstructed 8-bit pixels. The even-row pixel pair is emitted directly. The odd-row pair is held in a one-half-row line buffer and drained after the half-row completes, so the output leaves in raster order, two pixels per cycle, ready for the BMP writer.

---
 rtl/haar_inv_col_merge.sv | 176 +++++++++++++++++
 tb/tb_haar_inv_col_merge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/haar_inv_col_merge.sv
// Inverse Haar column merge: per-beat 2x2 reconstruction with an odd-row half-line buffer so pixels leave in raster order.
// Build option: define HAAR_SAT_EN to clamp results to 0..255 (default: keep the low 8 bits, wrap-around).
module haar_inv_col_merge #(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 30
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       hsync,
  input  logic [8:0] DATA_R_L0,
  input  logic [8:0] DATA_R_L1,
  input  logic [8:0] DATA_R_H0,
  input  logic [8:0] DATA_R_H1,
  input  logic [8:0] DATA_G_L0,
  input  logic [8:0] DATA_G_L1,
  input  logic [8:0] DATA_G_H0,
  input  logic [8:0] DATA_G_H1,
  input  logic [8:0] DATA_B_L0,
  input  logic [8:0] DATA_B_L1,
  input  logic [8:0] DATA_B_H0,
  input  logic [8:0] DATA_B_H1,
  output logic       ready,
  output logic       out_valid,
  output logic [7:0] DATA_R0,
  output logic [7:0] DATA_G0,
  output logic [7:0] DATA_B0,
  output logic [7:0] DATA_R1,
  output logic [7:0] DATA_G1,
  output logic [7:0] DATA_B1,
  output logic       ovf,
  output logic       ctrl_data_Done
);

  localparam int W2 = WIDTH / 2;
  localparam int H2 = HEIGHT / 2;
  localparam int CW = (W2 > 1) ? $clog2(W2) : 1;
  localparam int RW = (H2 > 1) ? $clog2(H2) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   col_reg, col_next;
  logic [RW-1:0]   row_reg, row_next;
  logic            frame_end_reg, frame_end_next;
  logic            out_valid_reg;
  logic [47:0]     out_word_reg;
  logic            ovf_reg;
  logic            done_reg;
  logic            accept;

  logic [8:0]  l0 [3];
  logic [8:0]  l1 [3];
  logic [8:0]  h0 [3];
  logic [8:0]  h1 [3];
  logic [15:0] even_pair [3];
  logic [15:0] odd_pair [3];
  logic [47:0] even_word, odd_word;

  // Odd-row pixel pairs wait here until the half-row has been fully received.
  logic [47:0] line_mem [W2];

  assign l0[0] = DATA_R_L0;  assign l1[0] = DATA_R_L1;
  assign h0[0] = DATA_R_H0;  assign h1[0] = DATA_R_H1;
  assign l0[1] = DATA_G_L0;  assign l1[1] = DATA_G_L1;
  assign h0[1] = DATA_G_H0;  assign h1[1] = DATA_G_H1;
  assign l0[2] = DATA_B_L0;  assign l1[2] = DATA_B_L1;
  assign h0[2] = DATA_B_H0;  assign h1[2] = DATA_B_H1;

  function automatic logic [7:0] reduce8(input logic signed [9:0] v);
`ifdef HAAR_SAT_EN
    if (v < 10'sd0)
      return 8'd0;
    else if (v > 10'sd255)
      return 8'd255;
    else
      return v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic signed [9:0] p0, p1, q0, q1;
      assign p0 = $signed({l0[gi][8], l0[gi]}) + $signed({h0[gi][8], h0[gi]});
      assign p1 = $signed({l0[gi][8], l0[gi]}) - $signed({h0[gi][8], h0[gi]});
      assign q0 = $signed({l1[gi][8], l1[gi]}) + $signed({h1[gi][8], h1[gi]});
      assign q1 = $signed({l1[gi][8], l1[gi]}) - $signed({h1[gi][8], h1[gi]});
      assign even_pair[gi] = {reduce8(p0), reduce8(p1)};
      assign odd_pair[gi]  = {reduce8(q0), reduce8(q1)};
    end
  endgenerate

  // Word layout: {R0,R1,G0,G1,B0,B1}.
  assign even_word = {even_pair[0], even_pair[1], even_pair[2]};
  assign odd_word  = {odd_pair[0], odd_pair[1], odd_pair[2]};

  assign ready  = (state_reg == FILL);
  assign accept = hsync && ready;

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    frame_end_next = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (col_reg == CW'(W2 - 1)) begin
            col_next   = '0;
            state_next = DRAIN;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (col_reg == CW'(W2 - 1)) begin
          col_next   = '0;
          state_next = FILL;
          if (row_reg == RW'(H2 - 1)) begin
            row_next       = '0;
            frame_end_next = 1'b1;
          end else begin
            row_next = row_reg + 1'b1;
          end
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (accept && !HRESET)
      line_mem[col_reg] <= odd_word;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg     <= FILL;
      col_reg       <= '0;
      row_reg       <= '0;
      frame_end_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
      ovf_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      frame_end_reg <= frame_end_next;
      ovf_reg       <= ovf_reg | (hsync & ~ready);
      // Done trails the last drained pair by one cycle.
      done_reg      <= done_reg | frame_end_reg;
      out_valid_reg <= accept || (state_reg == DRAIN);
      if (accept)
        out_word_reg <= even_word;
      else if (state_reg == DRAIN)
        out_word_reg <= line_mem[col_reg];
    end
  end

  assign out_valid      = out_valid_reg;
  assign ovf            = ovf_reg;
  assign ctrl_data_Done = done_reg;
  assign DATA_R0 = out_word_reg[47:40];
  assign DATA_R1 = out_word_reg[39:32];
  assign DATA_G0 = out_word_reg[31:24];
  assign DATA_G1 = out_word_reg[23:16];
  assign DATA_B0 = out_word_reg[15:8];
  assign DATA_B1 = out_word_reg[7:0];

endmodule

// File: tb/tb_haar_inv_col_merge.sv
// Directed bench for haar_inv_col_merge at WIDTH=4, HEIGHT=4 (two beats per half-row, two half-rows per frame).
module tb_haar_inv_col_merge;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 4;

  logic HCLK = 1'b0;
  logic HRESET, hsync;
  logic [8:0] DATA_R_L0, DATA_R_L1, DATA_R_H0, DATA_R_H1;
  logic [8:0] DATA_G_L0, DATA_G_L1, DATA_G_H0, DATA_G_H1;
  logic [8:0] DATA_B_L0, DATA_B_L1, DATA_B_H0, DATA_B_H1;
  logic ready, out_valid, ovf, ctrl_data_Done;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic [47:0] word;

  int checks = 0;
  int passed = 0;

  haar_inv_col_merge #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hsync(hsync),
    .DATA_R_L0(DATA_R_L0), .DATA_R_L1(DATA_R_L1), .DATA_R_H0(DATA_R_H0), .DATA_R_H1(DATA_R_H1),
    .DATA_G_L0(DATA_G_L0), .DATA_G_L1(DATA_G_L1), .DATA_G_H0(DATA_G_H0), .DATA_G_H1(DATA_G_H1),
    .DATA_B_L0(DATA_B_L0), .DATA_B_L1(DATA_B_L1), .DATA_B_H0(DATA_B_H0), .DATA_B_H1(DATA_B_H1),
    .ready(ready), .out_valid(out_valid),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .ovf(ovf), .ctrl_data_Done(ctrl_data_Done)
  );

  always #5 HCLK = ~HCLK;

  assign word = {DATA_R0, DATA_R1, DATA_G0, DATA_G1, DATA_B0, DATA_B1};

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] vp(input int r0, r1, g0, g1, b0, b1);
    return {1'b1, 8'(r0), 8'(r1), 8'(g0), 8'(g1), 8'(b0), 8'(b1)};
  endfunction

  task automatic set_rgb(input int rl0, rh0, rl1, rh1, gl0, gh0, gl1, gh1, bl0, bh0, bl1, bh1);
    DATA_R_L0 = 9'(rl0); DATA_R_H0 = 9'(rh0); DATA_R_L1 = 9'(rl1); DATA_R_H1 = 9'(rh1);
    DATA_G_L0 = 9'(gl0); DATA_G_H0 = 9'(gh0); DATA_G_L1 = 9'(gl1); DATA_G_H1 = 9'(gh1);
    DATA_B_L0 = 9'(bl0); DATA_B_H0 = 9'(bh0); DATA_B_L1 = 9'(bl1); DATA_B_H1 = 9'(bh1);
  endtask

  task automatic set_r(input int l0, h0, l1, h1);
    set_rgb(l0, h0, l1, h1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Full frame with hsync held high, so beats offered during drain are dropped.
  task automatic run_frame(input string pfx);
    hsync = 1'b1;
    set_r(10, 1, 20, 2);         tick();
    chk({pfx, " even A0"}, {out_valid, word}, vp(11, 9, 0, 0, 0, 0));
    chk({pfx, " ready A0"}, ready, 1);
    set_r(30, 3, 40, 4);         tick();
    chk({pfx, " even A1"}, {out_valid, word}, vp(33, 27, 0, 0, 0, 0));
    chk({pfx, " ready drain0"}, ready, 0);
    set_r(-100, -100, -100, -100); tick();
    chk({pfx, " odd A0"}, {out_valid, word}, vp(22, 18, 0, 0, 0, 0));
    chk({pfx, " ready drain1"}, ready, 0);
    chk({pfx, " ovf set"}, ovf, 1);
    tick();
    chk({pfx, " odd A1"}, {out_valid, word}, vp(44, 36, 0, 0, 0, 0));
    chk({pfx, " ready back"}, ready, 1);
    set_r(50, 5, 60, 6);         tick();
    chk({pfx, " even B0"}, {out_valid, word}, vp(55, 45, 0, 0, 0, 0));
    set_r(70, 7, 80, 8);         tick();
    chk({pfx, " even B1"}, {out_valid, word}, vp(77, 63, 0, 0, 0, 0));
    chk({pfx, " ready row1 drain"}, ready, 0);
    set_r(-100, -100, -100, -100); tick();
    chk({pfx, " odd B0"}, {out_valid, word}, vp(66, 54, 0, 0, 0, 0));
    chk({pfx, " done early"}, ctrl_data_Done, 0);
    tick();
    chk({pfx, " odd B1"}, {out_valid, word}, vp(88, 72, 0, 0, 0, 0));
    chk({pfx, " done at last drain"}, ctrl_data_Done, 0);
    chk({pfx, " ready after frame"}, ready, 1);
    hsync = 1'b0;
    tick();
    chk({pfx, " idle valid"}, out_valid, 0);
    chk({pfx, " done rises"}, ctrl_data_Done, 1);
    tick();
    chk({pfx, " done sticky"}, ctrl_data_Done, 1);
  endtask

  initial begin
    HRESET = 1'b1;
    hsync  = 1'b0;
    set_r(0, 0, 0, 0);
    tick(); tick();
    HRESET = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle out_valid", out_valid, 0);
      chk("idle ready", ready, 1);
      chk("idle data", word, 0);
      chk("idle ovf", ovf, 0);
      chk("idle done", ctrl_data_Done, 0);
    end

    // Single beat, then finish the row and watch the drain.
    hsync = 1'b1;
    set_rgb(100, 20, 50, -10, 10, 3, 7, 2, 0, 0, 1, 1);
    tick();
    hsync = 1'b0;
    chk("beat0 even", {out_valid, word}, vp(120, 80, 13, 7, 0, 0));
    chk("beat0 ready", ready, 1);
    tick();
    chk("gap valid", out_valid, 0);
    chk("gap hold", word, vp(120, 80, 13, 7, 0, 0) & 49'h0_FFFF_FFFF_FFFF);
    hsync = 1'b1;
    set_r(30, 5, 40, -20);
    tick();
    hsync = 1'b0;
    chk("beat1 even", {out_valid, word}, vp(35, 25, 0, 0, 0, 0));
    chk("beat1 ready", ready, 0);
    tick();
    chk("drain0", {out_valid, word}, vp(40, 60, 9, 5, 2, 0));
    tick();
    chk("drain1", {out_valid, word}, vp(20, 60, 0, 0, 0, 0));
    chk("drain end ready", ready, 1);
    tick();
    chk("post drain valid", out_valid, 0);
    chk("no ovf yet", ovf, 0);

    // Continuous hsync over a whole fresh frame.
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    run_frame("cont");

    // Saturation / wrap behaviour.
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    chk("reset clears done", ctrl_data_Done, 0);
    chk("reset clears ovf", ovf, 0);
    hsync = 1'b1;
    set_r(200, 100, -50, 20);
    tick();
`ifdef HAAR_SAT_EN
    chk("sat P0", DATA_R0, 255);
`else
    chk("wrap P0", DATA_R0, 44);
`endif
    chk("sat P1", DATA_R1, 100);
    set_r(0, 0, 0, 0);
    tick();
    hsync = 1'b0;
    tick();
`ifdef HAAR_SAT_EN
    chk("sat Q0", DATA_R0, 0);
    chk("sat Q1", DATA_R1, 0);
`else
    chk("wrap Q0", DATA_R0, 226);
    chk("wrap Q1", DATA_R1, 186);
`endif
    chk("mid drain ready", ready, 0);

    // Reset in the middle of the drain.
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rst drain ready", ready, 1);
    chk("rst drain valid", out_valid, 0);
    chk("rst drain data", word, 0);
    tick();
    chk("rst drain no leftover", out_valid, 0);
    run_frame("fresh");

    // Reset and a beat in the same cycle: the beat is ignored.
    HRESET = 1'b1;
    hsync  = 1'b1;
    set_r(100, 20, 50, -10);
    tick();
    HRESET = 1'b0;
    hsync  = 1'b0;
    chk("rst+beat valid", out_valid, 0);
    chk("rst+beat data", word, 0);
    chk("rst+beat ready", ready, 1);
    hsync = 1'b1;
    set_r(1, 1, 1, 1);
    tick();
    chk("post rst first beat ready", ready, 1);
    chk("post rst first beat", {out_valid, word}, vp(2, 0, 0, 0, 0, 0));
    set_r(2, 1, 2, 1);
    tick();
    hsync = 1'b0;
    chk("post rst second beat ready", ready, 0);
    tick();
    chk("post rst drain0", {out_valid, word}, vp(2, 0, 0, 0, 0, 0));
    tick();
    chk("post rst drain1", {out_valid, word}, vp(3, 1, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
